dsi_lane_arbiter: RTL and testbench
===================================

Name: dsi_lane_arbiter

Overview:
- Sequences the DSI lanes controller and shares its word interface between two packet sources: src0 (video stream) and src1 (command/LP packets).
- Per packet: arbitrates, enables the lanes and clock, waits for ready, streams words under the controller's data-request handshake, then returns the lanes to LP with a minimum gap.
- Sits between the packet assemblers and the lanes controller, in the clk_sys domain.

Parameters:
- READY_TIMEOUT, 1024: max clk_sys cycles in ENABLE waiting for lines_ready & clock_ready.
- GAP_CYCLES, 8: min cycles lanes stay disabled between packets (≥1).
- CLK_CONTINUOUS, 0: 1 = clock_enable stays high after first packet until rst; 0 = clock_enable follows lines_enable.
- CNT_W, 16: width of the timeout/gap counter (must hold max(READY_TIMEOUT, GAP_CYCLES)).

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s0_req / s1_req  in  1  source has a complete packet pending; sampled only in IDLE.
- s0_data / s1_data  in  32  packet word.
- s0_strb / s1_strb  in  4  byte strobe, 4'hf except possibly the last word (4'h1/3/7).
- s0_valid / s1_valid  in  1  word valid.
- s0_last / s1_last  in  1  final word of packet.
- s0_ready / s1_ready  out  1  word consumed this cycle.
- iface_write_data  out  32  to lanes controller.
- iface_write_strb  out  4  to lanes controller.
- iface_write_rqst  out  1  word valid to lanes controller.
- iface_last_word  out  1  final word marker.
- iface_data_rqst  in  1  lanes controller accepts a word this cycle.
- lines_enable  out  1  data-lane enable.
- clock_enable  out  1  clock-lane enable.
- lines_ready / clock_ready  in  1  lane status.
- data_underflow_error  in  1  pulse from lanes controller.
- grant  out  2  one-hot owner; 2'b00 when idle.
- busy  out  1  state != IDLE.
- err_timeout  out  1  one-cycle pulse on ENABLE timeout.
- err_underflow  out  1  sticky; set by data_underflow_error.
- err_clear  in  1  clears err_underflow.

Behaviour:
- Reset (async, immediate): state = IDLE; all outputs 0; last_grant = 1 so src0 wins the first tie; counters 0; err_underflow 0.
- FSM states: IDLE, ENABLE, STREAM, GAP.
- IDLE:
  - One request: grant that source. Both requests: round-robin, grant the source not in last_grant.
  - On grant: register grant and last_grant, clear counter, go to ENABLE next cycle. No request: stay in IDLE.
- ENABLE:
  - lines_enable = 1, clock_enable = 1; counter increments each cycle.
  - lines_ready & clock_ready both 1: go to STREAM.
  - Else counter == READY_TIMEOUT-1: pulse err_timeout, go to GAP. No words consumed; the request stays pending and is re-arbitrated.
- STREAM:
  - iface_write_data/strb/last_word are a combinational mux of the granted source's data/strb/last.
  - iface_write_rqst = granted sN_valid.
  - sN_ready = (granted N) & sN_valid & iface_data_rqst.
  - Transfer occurs on an edge where iface_write_rqst & iface_data_rqst, so throughput is 1 word/cycle when both are high.
  - Outside STREAM the mux outputs are 0 and iface_write_rqst = 0.
  - Transfer with last = 1: go to GAP next cycle.
  - Source must not drop valid mid-packet. If it does, the stall is passed through; the lanes controller may flag underflow.
- GAP:
  - lines_enable = 0. clock_enable = 0 unless CLK_CONTINUOUS; grant = 0.
  - Counts GAP_CYCLES, then additionally waits for lines_ready == 0, then goes to IDLE.
  - Minimum packet-to-packet spacing: GAP_CYCLES + 1 cycles.
- CLK_CONTINUOUS = 1: clock_enable latches 1 on the first ENABLE entry and holds until rst.
- Errors:
  - err_underflow sets on data_underflow_error in any state.
  - err_clear clears it; set wins if both occur in the same cycle.
- s*_req changes outside IDLE are ignored; requests are never lost.
- Single-word packets (valid & last on the first word) are legal.

Test Plan:
- src0-only packet of 5 words (strb f,f,f,f,1), ready after 3 cycles, iface_data_rqst held 1 -> grant=01; 5 transfers on consecutive cycles; iface_last_word only on word 5 with strb 4'h1; lines_enable falls the cycle after; busy low after GAP_CYCLES plus lines_ready low.
- s0_req and s1_req both asserted from reset, each sending a 3-word packet, repeated 4 times -> grant order 01,10,01,10,…; no word interleaving between sources.
- iface_data_rqst toggled randomly (0–6 cycle runs) on a 64-word packet -> every word transferred exactly once in order; sN_ready high only when iface_data_rqst high.
- lines_ready held 0 with READY_TIMEOUT=16 -> err_timeout pulses 1 cycle at the 16th ENABLE cycle; no sN_ready; enters GAP then retries the same source.
- CLK_CONTINUOUS=1, two packets -> clock_enable stays 1 across the GAP while lines_enable drops.
- rst asserted mid-STREAM (word 3 of 10) -> all outputs 0 asynchronously; after release, state IDLE and arbitration restarts with src0 priority. Separately, data_underflow_error pulse -> err_underflow sticks until err_clear.

Source files
------------

// File: rtl/dsi_lane_arbiter.sv
// Shares the DSI lanes controller word interface between a video source (src0) and a
// command source (src1), sequencing lane/clock enable, streaming and the inter-packet gap.
module dsi_lane_arbiter #(
    parameter int READY_TIMEOUT  = 1024,
    parameter int GAP_CYCLES     = 8,
    parameter int CLK_CONTINUOUS = 0,
    parameter int CNT_W          = 16
) (
    input  logic        clk_sys,
    input  logic        rst,

    input  logic        s0_req,
    input  logic [31:0] s0_data,
    input  logic [3:0]  s0_strb,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,

    input  logic        s1_req,
    input  logic [31:0] s1_data,
    input  logic [3:0]  s1_strb,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,

    output logic [31:0] iface_write_data,
    output logic [3:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    input  logic        iface_data_rqst,

    output logic        lines_enable,
    output logic        clock_enable,
    input  logic        lines_ready,
    input  logic        clock_ready,
    input  logic        data_underflow_error,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_underflow,
    input  logic        err_clear
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ENABLE, STREAM, GAP} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       grant_q;
    logic [1:0]       grant_next;
    logic             last_grant;
    logic             last_grant_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             clk_latched;
    logic             err_underflow_q;

    logic             lanes_up;
    logic             xfer;
    logic             sel_valid;
    logic             sel_last;
    logic [31:0]      sel_data;
    logic [3:0]       sel_strb;

    assign lanes_up  = lines_ready & clock_ready;
    assign sel_valid = grant_q[1] ? s1_valid : s0_valid;
    assign sel_last  = grant_q[1] ? s1_last  : s0_last;
    assign sel_data  = grant_q[1] ? s1_data  : s0_data;
    assign sel_strb  = grant_q[1] ? s1_strb  : s0_strb;
    assign xfer      = (state == STREAM) & sel_valid & iface_data_rqst;

    // last_grant resets to src1 so that src0 wins the first simultaneous request.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            grant_q    <= grant_next;
            last_grant <= last_grant_next;
            cnt        <= cnt_next;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            clk_latched     <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            if (state == ENABLE)
                clk_latched <= 1'b1;
            if (data_underflow_error)
                err_underflow_q <= 1'b1;
            else if (err_clear)
                err_underflow_q <= 1'b0;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant_q;
        last_grant_next = last_grant;
        cnt_next        = cnt;
        case (state)
            IDLE: begin
                if (s0_req && (!s1_req || last_grant)) begin
                    grant_next      = 2'b01;
                    last_grant_next = 1'b0;
                    cnt_next        = '0;
                    state_next      = ENABLE;
                end else if (s1_req) begin
                    grant_next      = 2'b10;
                    last_grant_next = 1'b1;
                    cnt_next        = '0;
                    state_next      = ENABLE;
                end
            end
            ENABLE: begin
                cnt_next = cnt + CNT_W'(1);
                if (lanes_up) begin
                    state_next = STREAM;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end
            end
            STREAM: begin
                if (xfer && sel_last) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end
            end
            GAP: begin
                // The minimum gap is served first; only then do we wait for the lanes to report LP.
                if (cnt < GAP_LAST)
                    cnt_next = cnt + CNT_W'(1);
                else if (!lines_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s0_ready         = 1'b0;
        s1_ready         = 1'b0;
        iface_write_data = '0;
        iface_write_strb = '0;
        iface_write_rqst = 1'b0;
        iface_last_word  = 1'b0;
        lines_enable     = 1'b0;
        clock_enable     = (CLK_CONTINUOUS != 0) & clk_latched;
        grant            = 2'b00;
        busy             = (state != IDLE);
        err_timeout      = 1'b0;
        case (state)
            ENABLE: begin
                lines_enable = 1'b1;
                clock_enable = 1'b1;
                grant        = grant_q;
                err_timeout  = !lanes_up && (cnt == TIMEOUT_LAST);
            end
            STREAM: begin
                lines_enable     = 1'b1;
                clock_enable     = 1'b1;
                grant            = grant_q;
                iface_write_data = sel_data;
                iface_write_strb = sel_strb;
                iface_last_word  = sel_last;
                iface_write_rqst = sel_valid;
                s0_ready         = grant_q[0] & s0_valid & iface_data_rqst;
                s1_ready         = grant_q[1] & s1_valid & iface_data_rqst;
            end
            default: ;
        endcase
    end

    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_dsi_lane_arbiter.sv
// Scoreboard bench for dsi_lane_arbiter: a lanes-controller model plus two packet sources;
// a second instance with continuous clock runs on the same stimulus.
module tb_dsi_lane_arbiter;

    localparam int GAP = 4;
    localparam int TO  = 16;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        s0_req, s0_valid, s0_last, s1_req, s1_valid, s1_last;
    logic [31:0] s0_data, s1_data;
    logic [3:0]  s0_strb, s1_strb;
    logic        iface_data_rqst, lines_ready, clock_ready;
    logic        data_underflow_error, err_clear;

    logic        s0_ready, s1_ready, iface_write_rqst, iface_last_word;
    logic [31:0] iface_write_data;
    logic [3:0]  iface_write_strb;
    logic        lines_enable, clock_enable, busy, err_timeout, err_underflow;
    logic [1:0]  grant;

    logic        cc_s0_ready, cc_s1_ready, cc_rqst, cc_last;
    logic [31:0] cc_data;
    logic [3:0]  cc_strb;
    logic        cc_lines_enable, cc_clock_enable, cc_busy, cc_err_timeout, cc_err_underflow;
    logic [1:0]  cc_grant;

    always #5 clk_sys = ~clk_sys;

    dsi_lane_arbiter #(.READY_TIMEOUT(TO), .GAP_CYCLES(GAP), .CLK_CONTINUOUS(0), .CNT_W(16)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .s0_req(s0_req), .s0_data(s0_data), .s0_strb(s0_strb), .s0_valid(s0_valid),
        .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_req(s1_req), .s1_data(s1_data), .s1_strb(s1_strb), .s1_valid(s1_valid),
        .s1_last(s1_last), .s1_ready(s1_ready),
        .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
        .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
        .iface_data_rqst(iface_data_rqst),
        .lines_enable(lines_enable), .clock_enable(clock_enable),
        .lines_ready(lines_ready), .clock_ready(clock_ready),
        .data_underflow_error(data_underflow_error),
        .grant(grant), .busy(busy), .err_timeout(err_timeout),
        .err_underflow(err_underflow), .err_clear(err_clear)
    );

    dsi_lane_arbiter #(.READY_TIMEOUT(TO), .GAP_CYCLES(GAP), .CLK_CONTINUOUS(1), .CNT_W(16)) dut_cc (
        .clk_sys(clk_sys), .rst(rst),
        .s0_req(s0_req), .s0_data(s0_data), .s0_strb(s0_strb), .s0_valid(s0_valid),
        .s0_last(s0_last), .s0_ready(cc_s0_ready),
        .s1_req(s1_req), .s1_data(s1_data), .s1_strb(s1_strb), .s1_valid(s1_valid),
        .s1_last(s1_last), .s1_ready(cc_s1_ready),
        .iface_write_data(cc_data), .iface_write_strb(cc_strb),
        .iface_write_rqst(cc_rqst), .iface_last_word(cc_last),
        .iface_data_rqst(iface_data_rqst),
        .lines_enable(cc_lines_enable), .clock_enable(cc_clock_enable),
        .lines_ready(lines_ready), .clock_ready(clock_ready),
        .data_underflow_error(data_underflow_error),
        .grant(cc_grant), .busy(cc_busy), .err_timeout(cc_err_timeout),
        .err_underflow(cc_err_underflow), .err_clear(err_clear)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [1:0]  grant;
    } exp_t;

    exp_t sb_q[$];
    int   xfer_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   xfer_done = 0;
    logic hold_off = 1'b0;
    logic drv_abort = 1'b0;
    logic rqst_random = 1'b0;
    int   rqst_run = 0;
    int   on_cnt, off_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Lanes controller model: ready 3 cycles after enable, drops 6 cycles after disable.
    always @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            on_cnt <= 0;
            off_cnt <= 0;
            lines_ready <= 1'b0;
        end else if (lines_enable) begin
            off_cnt <= 0;
            on_cnt <= (on_cnt < 15) ? on_cnt + 1 : on_cnt;
            lines_ready <= !hold_off && (on_cnt >= 2);
        end else begin
            on_cnt <= 0;
            off_cnt <= (off_cnt < 15) ? off_cnt + 1 : off_cnt;
            lines_ready <= lines_ready && (off_cnt < 5) && !hold_off;
        end
    end
    assign clock_ready = lines_ready;

    initial begin
        iface_data_rqst = 1'b1;
        forever begin
            @(posedge clk_sys);
            #1;
            if (rqst_random) begin
                if (rqst_run <= 0) begin
                    iface_data_rqst = ~iface_data_rqst;
                    rqst_run = $urandom_range(6, 1);
                end
                rqst_run--;
            end else begin
                iface_data_rqst = 1'b1;
            end
        end
    end

    always @(negedge clk_sys) begin
        exp_t e;
        cycle++;
        if (!rst) begin
            if (iface_write_rqst && iface_data_rqst) begin
                if (sb_q.size() == 0) begin
                    checkOutput("xfer_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("iface_data", iface_write_data, e.data);
                    checkOutput("iface_strb", iface_write_strb, e.strb);
                    checkOutput("iface_last", iface_last_word, e.last);
                    checkOutput("grant", grant, e.grant);
                end
                xfer_done++;
                xfer_cyc_q.push_back(cycle);
            end
            if (s0_ready) checkOutput("s0_ready_rqst", iface_data_rqst, 1);
            if (s1_ready) checkOutput("s1_ready_rqst", iface_data_rqst, 1);
        end
    end

    function automatic logic [31:0] word_data(input int src, input logic [7:0] pkt, input int w);
        return {4'(src), pkt, 20'(w)};
    endfunction

    function automatic logic [3:0] word_strb(input int n, input int w);
        if (w != n - 1) return 4'hf;
        case (n % 4)
            1: return 4'h1;
            2: return 4'h3;
            3: return 4'h7;
            default: return 4'hf;
        endcase
    endfunction

    function automatic logic src_ready(input int src);
        return (src == 0) ? s0_ready : s1_ready;
    endfunction

    task automatic set_src(input int src, input logic req, input logic v,
                           input logic [31:0] d, input logic [3:0] s, input logic l);
        if (src == 0) begin
            s0_req = req; s0_valid = v; s0_data = d; s0_strb = s; s0_last = l;
        end else begin
            s1_req = req; s1_valid = v; s1_data = d; s1_strb = s; s1_last = l;
        end
    endtask

    task automatic push_expected(input int src, input int n, input logic [7:0] pkt, input logic [1:0] g);
        for (int w = 0; w < n; w++)
            sb_q.push_back({word_data(src, pkt, w), word_strb(n, w), 1'(w == n - 1), g});
    endtask

    // Presents one packet word by word, holding each until the arbiter consumes it.
    task automatic applyStimulus(input int src, input int n, input logic [7:0] pkt);
        for (int w = 0; w < n; w++) begin
            int budget;
            budget = 0;
            set_src(src, 1'b1, 1'b1, word_data(src, pkt, w), word_strb(n, w), 1'(w == n - 1));
            @(negedge clk_sys);
            while (!src_ready(src) && !drv_abort && budget < 2000) begin
                @(negedge clk_sys);
                budget++;
            end
            if (budget >= 2000) checkOutput("src_wait_timeout", 0, 1);
            if (drv_abort || budget >= 2000) break;
            @(posedge clk_sys);
            #1;
        end
        set_src(src, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_xfers(input int target);
        int b;
        b = 0;
        while (xfer_done < target && b < 1000) begin
            @(negedge clk_sys);
            #1;
            b++;
        end
        if (xfer_done < target) checkOutput("xfer_wait_timeout", xfer_done, target);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (busy && b < 1000) begin
            @(negedge clk_sys);
            #1;
            b++;
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        @(negedge clk_sys);
        #1;
    endtask

    initial begin
        int base, gap_len, pulses, first_pulse, ready_seen;
        logic prev_lr;
        rst = 1'b1;
        set_src(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_src(1, 1'b0, 1'b0, '0, '0, 1'b0);
        data_underflow_error = 1'b0;
        err_clear = 1'b0;
        do_reset();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_lines_en", lines_enable, 0);
        checkOutput("rst_clock_en", clock_enable, 0);
        checkOutput("rst_cc_clock_en", cc_clock_enable, 0);
        checkOutput("rst_write_rqst", iface_write_rqst, 0);
        checkOutput("rst_err_underflow", err_underflow, 0);

        // src0 alone, 5 words back to back
        push_expected(0, 5, 8'h01, 2'b01);
        xfer_cyc_q.delete();
        base = xfer_done;
        fork
            applyStimulus(0, 5, 8'h01);
            begin
                wait_xfers(base + 5);
                @(negedge clk_sys);
                #1;
                checkOutput("gap_lines_en", lines_enable, 0);
                checkOutput("gap_clock_en", clock_enable, 0);
                checkOutput("gap_cc_lines_en", cc_lines_enable, 0);
                checkOutput("gap_cc_clock_en", cc_clock_enable, 1);
                checkOutput("gap_grant", grant, 0);
                gap_len = 0;
                prev_lr = 1'b1;
                while (busy && gap_len < 100) begin
                    prev_lr = lines_ready;
                    gap_len++;
                    @(negedge clk_sys);
                    #1;
                end
                // 4 counted cycles, then held until the lane model drops ready 6 edges in
                checkOutput("gap_len", gap_len, 7);
                checkOutput("gap_exit_ready_low", prev_lr, 0);
            end
        join
        if (xfer_cyc_q.size() == 5) checkOutput("burst_span", xfer_cyc_q[4] - xfer_cyc_q[0], 4);
        else checkOutput("burst_count", xfer_cyc_q.size(), 5);
        checkOutput("cc_clock_held_idle", cc_clock_enable, 1);

        // Round robin from reset: src0 first, then strictly alternating
        do_reset();
        checkOutput("rr_rst_cc_clock_en", cc_clock_enable, 0);
        for (int k = 0; k < 4; k++) begin
            push_expected(0, 3, 8'(8'h10 + k), 2'b01);
            push_expected(1, 3, 8'(8'h20 + k), 2'b10);
        end
        fork
            for (int k = 0; k < 4; k++) applyStimulus(0, 3, 8'(8'h10 + k));
            for (int k = 0; k < 4; k++) applyStimulus(1, 3, 8'(8'h20 + k));
        join
        wait_idle();
        checkOutput("rr_sb_empty", sb_q.size(), 0);

        // Long src1 packet under a randomly throttled data request
        rqst_random = 1'b1;
        push_expected(1, 64, 8'h30, 2'b10);
        applyStimulus(1, 64, 8'h30);
        rqst_random = 1'b0;
        wait_idle();
        checkOutput("rand_sb_empty", sb_q.size(), 0);

        // Lanes never ready: timeout, gap, retry of the same source
        hold_off = 1'b1;
        push_expected(0, 2, 8'h40, 2'b01);
        fork
            applyStimulus(0, 2, 8'h40);
            begin
                base = 0;
                while (!lines_enable && base < 20) begin
                    @(negedge clk_sys);
                    #1;
                    base++;
                end
                pulses = 0;
                first_pulse = 0;
                ready_seen = 0;
                for (int i = 1; i <= 24; i++) begin
                    if (err_timeout) begin
                        pulses++;
                        if (first_pulse == 0) first_pulse = i;
                    end
                    if (s0_ready) ready_seen++;
                    if (i < 24) begin
                        @(negedge clk_sys);
                        #1;
                    end
                end
                checkOutput("timeout_cycle", first_pulse, TO);
                checkOutput("timeout_pulses", pulses, 1);
                checkOutput("timeout_no_ready", ready_seen, 0);
                checkOutput("retry_lines_en", lines_enable, 1);
                checkOutput("retry_grant", grant, 2'b01);
                hold_off = 1'b0;
            end
        join
        wait_idle();
        checkOutput("timeout_sb_empty", sb_q.size(), 0);

        // Asynchronous reset in the middle of a 10-word packet
        push_expected(0, 10, 8'h50, 2'b01);
        base = xfer_done;
        fork
            applyStimulus(0, 10, 8'h50);
            begin
                wait_xfers(base + 2);
                @(posedge clk_sys);
                #2;
                rst = 1'b1;
                drv_abort = 1'b1;
                #1;
                checkOutput("arst_lines_en", lines_enable, 0);
                checkOutput("arst_clock_en", clock_enable, 0);
                checkOutput("arst_grant", grant, 0);
                checkOutput("arst_busy", busy, 0);
                checkOutput("arst_write_rqst", iface_write_rqst, 0);
                checkOutput("arst_write_data", iface_write_data, 0);
                checkOutput("arst_s0_ready", s0_ready, 0);
            end
        join
        sb_q.delete();
        drv_abort = 1'b0;
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        push_expected(0, 2, 8'h60, 2'b01);
        push_expected(1, 2, 8'h61, 2'b10);
        fork
            applyStimulus(0, 2, 8'h60);
            applyStimulus(1, 2, 8'h61);
        join
        wait_idle();
        checkOutput("post_rst_sb_empty", sb_q.size(), 0);

        // Sticky underflow flag; set has priority over clear
        @(posedge clk_sys); #1;
        data_underflow_error = 1'b1;
        @(posedge clk_sys); #1;
        data_underflow_error = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("underflow_sticky", err_underflow, 1);
        data_underflow_error = 1'b1;
        err_clear = 1'b1;
        @(posedge clk_sys); #1;
        data_underflow_error = 1'b0;
        checkOutput("underflow_set_wins", err_underflow, 1);
        @(posedge clk_sys); #1;
        err_clear = 1'b0;
        checkOutput("underflow_cleared", err_underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
